// File: rtl/gbe_rx_mux.sv
// UDP receive demultiplexer: parses Ethernet/IPv4/UDP headers and forwards payload of matching
// frames to one of NUM_PORTS channels. Define GBE_RX_MUX_BCAST_EN to also accept broadcast MAC.
module gbe_rx_mux #(
   parameter int unsigned NUM_PORTS    = 4,
   parameter int unsigned PORT_BASE_EN = 0
) (
   input  logic                     app_clk,
   input  logic                     app_rst,
   input  logic [7:0]               mac_rx_data,
   input  logic                     mac_rx_dvld,
   input  logic                     mac_rx_goodframe,
   input  logic                     mac_rx_badframe,
   input  logic                     local_enable,
   input  logic [47:0]              local_mac,
   input  logic [31:0]              local_ip,
   input  logic [16*NUM_PORTS-1:0]  local_ports,
   input  logic [15:0]              local_port_base,
   input  logic [NUM_PORTS-1:0]     port_en,
   output logic [7:0]               app_data,
   output logic                     app_dvld,
   output logic                     app_eof,
   output logic                     app_badframe,
   output logic [2:0]               app_chan,
   output logic [31:0]              app_srcip,
   output logic [15:0]              app_srcport,
   output logic [15:0]              stat_drop
);

`ifdef GBE_RX_MUX_BCAST_EN
   localparam bit BcastEn = 1'b1;
`else
   localparam bit BcastEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrop} state_e;

   state_e      state_q, state_d;
   logic [5:0]  off_q, off_d;
   logic        ucast_q, ucast_d, bcast_q, bcast_d;
   logic        sync_q, sync_d;
   logic [31:0] ip_cap_q, ip_cap_d;
   logic [15:0] sport_cap_q, sport_cap_d;
   logic [7:0]  hi_q, hi_d;
   logic [2:0]  chan_cap_q, chan_cap_d;
   logic [15:0] rem_q, rem_d;
   logic [7:0]  data_q, data_d;
   logic        dvld_q, dvld_d, eof_q, eof_d, bad_q, bad_d;
   logic [2:0]  chan_q, chan_d;
   logic [31:0] srcip_q, srcip_d;
   logic [15:0] srcport_q, srcport_d;
   logic [15:0] drop_q, drop_d;

   logic        frame_end, byte_vld, hdr_byte, first, hdr_ok;
   logic [5:0]  cur_off;
   logic [47:0] mac_sh;
   logic [1:0]  ip_idx;
   logic [31:0] ip_sh;
   logic [15:0] cur_word;
   logic        port_hit;
   logic [2:0]  port_idx;
   logic [15:0] port_val [NUM_PORTS];
   logic        unused_cfg;

   assign unused_cfg = ^{local_ports, local_port_base};

   // A byte coinciding with a frame-end pulse is dropped.
   assign frame_end = mac_rx_goodframe | mac_rx_badframe;
   assign byte_vld  = mac_rx_dvld & ~frame_end;
   assign first     = (state_q == StIdle);
   assign hdr_byte  = byte_vld && ((first && sync_q) || state_q == StHdr);
   assign cur_off   = first ? 6'd0 : off_q;
   assign mac_sh    = local_mac << {cur_off[2:0], 3'b000};
   assign ip_idx    = cur_off[1:0] - 2'd2;
   assign ip_sh     = local_ip << {ip_idx, 3'b000};
   assign cur_word  = {hi_q, mac_rx_data};

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      if (PORT_BASE_EN != 0) begin : g_base
         assign port_val[g] = local_port_base + 16'(g);
      end else begin : g_list
         assign port_val[g] = local_ports[16*g +: 16];
      end
   end

   // Scan downwards so the lowest matching channel wins.
   always_comb begin
      port_hit = 1'b0;
      port_idx = 3'd0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_en[i] && port_val[i] == cur_word) begin
            port_hit = 1'b1;
            port_idx = 3'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      ucast_d     = ucast_q;
      bcast_d     = bcast_q;
      sync_d      = sync_q | frame_end;
      ip_cap_d    = ip_cap_q;
      sport_cap_d = sport_cap_q;
      hi_d        = hi_q;
      chan_cap_d  = chan_cap_q;
      rem_d       = rem_q;
      data_d      = data_q;
      dvld_d      = 1'b0;
      eof_d       = 1'b0;
      bad_d       = 1'b0;
      chan_d      = chan_q;
      srcip_d     = srcip_q;
      srcport_d   = srcport_q;
      drop_d      = drop_q;
      hdr_ok      = 1'b1;
      if (frame_end) begin
         state_d = StIdle;
         if (state_q == StPayload) begin
            eof_d = 1'b1;
            bad_d = mac_rx_badframe || (rem_q != 16'd0);
         end
      end else if (hdr_byte) begin
         off_d = cur_off + 6'd1;
         case (cur_off)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
               ucast_d = (first || ucast_q) && (mac_rx_data == mac_sh[47:40]);
               bcast_d = (first || bcast_q) && (mac_rx_data == 8'hFF);
               hdr_ok  = (ucast_d || (BcastEn && bcast_d)) && (!first || local_enable);
            end
            6'd12: hdr_ok = (mac_rx_data == 8'h08);
            6'd13: hdr_ok = (mac_rx_data == 8'h00);
            6'd14: hdr_ok = (mac_rx_data == 8'h45);
            6'd23: hdr_ok = (mac_rx_data == 8'h11);
            6'd26, 6'd27, 6'd28, 6'd29: ip_cap_d = {ip_cap_q[23:0], mac_rx_data};
            6'd30, 6'd31, 6'd32, 6'd33: hdr_ok = (mac_rx_data == ip_sh[31:24]);
            6'd34, 6'd35: sport_cap_d = {sport_cap_q[7:0], mac_rx_data};
            6'd36, 6'd38: hi_d = mac_rx_data;
            6'd37: begin
               hdr_ok     = port_hit;
               chan_cap_d = port_idx;
            end
            6'd39: begin
               hdr_ok = (cur_word >= 16'd9);
               rem_d  = cur_word - 16'd8;
            end
            default: ;
         endcase
         if (!hdr_ok) begin
            state_d = StDrop;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end else if (cur_off == 6'd41) begin
            state_d   = StPayload;
            chan_d    = chan_cap_q;
            srcip_d   = ip_cap_q;
            srcport_d = sport_cap_q;
         end else begin
            state_d = StHdr;
         end
      end else if (byte_vld && state_q == StPayload && rem_q != 16'd0) begin
         // Down-counter trims Ethernet pad beyond the UDP length.
         dvld_d = 1'b1;
         data_d = mac_rx_data;
         rem_d  = rem_q - 16'd1;
      end
   end

   always_ff @(posedge app_clk or posedge app_rst) begin
      if (app_rst) begin
         state_q     <= StIdle;
         off_q       <= 6'd0;
         ucast_q     <= 1'b0;
         bcast_q     <= 1'b0;
         sync_q      <= 1'b0;
         ip_cap_q    <= 32'd0;
         sport_cap_q <= 16'd0;
         hi_q        <= 8'd0;
         chan_cap_q  <= 3'd0;
         rem_q       <= 16'd0;
         data_q      <= 8'd0;
         dvld_q      <= 1'b0;
         eof_q       <= 1'b0;
         bad_q       <= 1'b0;
         chan_q      <= 3'd0;
         srcip_q     <= 32'd0;
         srcport_q   <= 16'd0;
         drop_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         ucast_q     <= ucast_d;
         bcast_q     <= bcast_d;
         sync_q      <= sync_d;
         ip_cap_q    <= ip_cap_d;
         sport_cap_q <= sport_cap_d;
         hi_q        <= hi_d;
         chan_cap_q  <= chan_cap_d;
         rem_q       <= rem_d;
         data_q      <= data_d;
         dvld_q      <= dvld_d;
         eof_q       <= eof_d;
         bad_q       <= bad_d;
         chan_q      <= chan_d;
         srcip_q     <= srcip_d;
         srcport_q   <= srcport_d;
         drop_q      <= drop_d;
      end
   end

   assign app_data     = data_q;
   assign app_dvld     = dvld_q;
   assign app_eof      = eof_q;
   assign app_badframe = bad_q;
   assign app_chan     = chan_q;
   assign app_srcip    = srcip_q;
   assign app_srcport  = srcport_q;
   assign stat_drop    = drop_q;

endmodule

// File: tb/tb_gbe_rx_mux.sv
// Directed self-checking bench for gbe_rx_mux: builds UDP frames byte by byte and checks
// payload delivery, padding, drops, bad endings, channel priority and mid-frame reset.
module tb_gbe_rx_mux;
   localparam int unsigned NP       = 4;
   localparam logic [47:0] MY_MAC   = 48'h02_11_22_33_44_55;
   localparam logic [31:0] MY_IP    = 32'hC0A8_0102;
   localparam logic [31:0] SRC_IP   = 32'h0A00_0007;
   localparam logic [15:0] SRC_PORT = 16'd1234;
   localparam logic [16*NP-1:0] PORTS_DEF = {16'd7000, 16'd5002, 16'd5001, 16'd5000};

   logic              app_clk = 1'b0;
   logic              app_rst;
   logic [7:0]        mac_rx_data;
   logic              mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe;
   logic              local_enable;
   logic [47:0]       local_mac;
   logic [31:0]       local_ip;
   logic [16*NP-1:0]  local_ports;
   logic [15:0]       local_port_base;
   logic [NP-1:0]     port_en;
   logic [7:0]        app_data;
   logic              app_dvld, app_eof, app_badframe;
   logic [2:0]        app_chan;
   logic [31:0]       app_srcip;
   logic [15:0]       app_srcport, stat_drop;

   gbe_rx_mux #(.NUM_PORTS(NP), .PORT_BASE_EN(0)) dut (
      .app_clk(app_clk), .app_rst(app_rst),
      .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
      .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
      .local_enable(local_enable), .local_mac(local_mac), .local_ip(local_ip),
      .local_ports(local_ports), .local_port_base(local_port_base), .port_en(port_en),
      .app_data(app_data), .app_dvld(app_dvld), .app_eof(app_eof),
      .app_badframe(app_badframe), .app_chan(app_chan), .app_srcip(app_srcip),
      .app_srcport(app_srcport), .stat_drop(stat_drop)
   );

   always #5 app_clk = ~app_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_drop = 0;
   int eof_cnt, first_dvld_cyc, pay_drv_cyc;
   logic        last_bad;
   logic [2:0]  last_chan;
   logic [31:0] last_ip;
   logic [15:0] last_port;
   logic [7:0]  rx_q [$];
   logic [7:0]  frm [$];

   always @(posedge app_clk) cyc++;

   always @(negedge app_clk) begin
      if (app_dvld) begin
         if (rx_q.size() == 0) first_dvld_cyc = cyc;
         rx_q.push_back(app_data);
      end
      if (app_eof) begin
         eof_cnt++;
         last_bad  = app_badframe;
         last_chan = app_chan;
         last_ip   = app_srcip;
         last_port = app_srcport;
      end
   end

   task automatic clear_mon();
      rx_q.delete();
      eof_cnt = 0;
      last_bad = 1'b0;
      first_dvld_cyc = -1;
   endtask

   task automatic push_n(input logic [47:0] v, input int n);
      for (int i = 0; i < n; i++) frm.push_back(v[8*(n-1-i) +: 8]);
   endtask

   task automatic build(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] dport,
                        input logic [15:0] ulen, input int plen, input int min_len);
      frm.delete();
      push_n(dmac, 6);
      push_n(48'h02AABBCCDDEE, 6);
      push_n(48'h0800, 2);
      push_n(48'h45, 1);
      push_n(48'h00, 1);
      push_n(48'(28 + plen), 2);
      push_n(48'h0, 4);
      push_n(48'h40, 1);
      push_n(48'h11, 1);
      push_n(48'h0, 2);
      push_n(48'(SRC_IP), 4);
      push_n(48'(dip), 4);
      push_n(48'(SRC_PORT), 2);
      push_n(48'(dport), 2);
      push_n(48'(ulen), 2);
      push_n(48'h0, 2);
      for (int i = 0; i < plen; i++) frm.push_back(8'hA0 + 8'(i));
      while (frm.size() < min_len) frm.push_back(8'h00);
   endtask

   // end_kind: bit0 goodframe, bit1 badframe, 0 = no frame end
   task automatic send(input int first, input int last, input logic [1:0] end_kind);
      for (int i = first; i < last && i < frm.size(); i++) begin
         @(negedge app_clk);
         mac_rx_data = frm[i];
         mac_rx_dvld = 1'b1;
         if (i == 42) pay_drv_cyc = cyc;
      end
      @(negedge app_clk);
      mac_rx_dvld      = 1'b0;
      mac_rx_goodframe = end_kind[0];
      mac_rx_badframe  = end_kind[1];
      @(negedge app_clk);
      mac_rx_goodframe = 1'b0;
      mac_rx_badframe  = 1'b0;
      repeat (3) @(negedge app_clk);
   endtask

   task automatic test_reset();
      app_rst = 1'b0;
      #2 app_rst = 1'b1;
      repeat (2) @(negedge app_clk);
      n_checks += 8;
      if (app_data !== 8'd0) begin n_fail++; $display("FAIL rst_data got %h exp 00", app_data); end
      if (app_dvld !== 1'b0) begin n_fail++; $display("FAIL rst_dvld got %b exp 0", app_dvld); end
      if (app_eof !== 1'b0) begin n_fail++; $display("FAIL rst_eof got %b exp 0", app_eof); end
      if (app_badframe !== 1'b0) begin n_fail++; $display("FAIL rst_bad got %b exp 0", app_badframe); end
      if (app_chan !== 3'd0) begin n_fail++; $display("FAIL rst_chan got %0d exp 0", app_chan); end
      if (app_srcip !== 32'd0) begin n_fail++; $display("FAIL rst_srcip got %h exp 0", app_srcip); end
      if (app_srcport !== 16'd0) begin n_fail++; $display("FAIL rst_srcport got %h exp 0", app_srcport); end
      if (stat_drop !== 16'd0) begin n_fail++; $display("FAIL rst_drop got %0d exp 0", stat_drop); end
      app_rst = 1'b0;
      exp_drop = 0;
      // Receiver stays out of frame until it has seen one frame end.
      send(0, 0, 2'b01);
   endtask

   task automatic test_basic();
      clear_mon();
      build(MY_MAC, MY_IP, 16'd5001, 16'd12, 4, 0);
      send(0, frm.size(), 2'b01);
      n_checks += 7;
      if (rx_q.size() != 4) begin n_fail++; $display("FAIL basic_count got %0d exp 4", rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < 4; i++) begin
         n_checks++;
         if (rx_q[i] !== 8'hA0 + 8'(i)) begin
            n_fail++; $display("FAIL basic_byte%0d got %h exp %h", i, rx_q[i], 8'hA0 + 8'(i));
         end
      end
      if (first_dvld_cyc != pay_drv_cyc + 1) begin
         n_fail++; $display("FAIL basic_latency got %0d exp %0d", first_dvld_cyc, pay_drv_cyc + 1);
      end
      if (eof_cnt != 1 || last_bad !== 1'b0) begin
         n_fail++; $display("FAIL basic_eof got cnt %0d bad %b exp cnt 1 bad 0", eof_cnt, last_bad);
      end
      if (last_chan !== 3'd1) begin n_fail++; $display("FAIL basic_chan got %0d exp 1", last_chan); end
      if (last_ip !== SRC_IP) begin n_fail++; $display("FAIL basic_srcip got %h exp %h", last_ip, SRC_IP); end
      if (last_port !== SRC_PORT) begin n_fail++; $display("FAIL basic_srcport got %0d exp %0d", last_port, SRC_PORT); end
      if (app_chan !== 3'd1) begin n_fail++; $display("FAIL basic_chan_hold got %0d exp 1", app_chan); end
   endtask

   task automatic test_pad();
      clear_mon();
      build(MY_MAC, MY_IP, 16'd5002, 16'd10, 2, 60);
      send(0, frm.size(), 2'b01);
      n_checks += 4;
      if (rx_q.size() != 2) begin n_fail++; $display("FAIL pad_count got %0d exp 2", rx_q.size()); end
      if (rx_q.size() > 1 && (rx_q[0] !== 8'hA0 || rx_q[1] !== 8'hA1)) begin
         n_fail++; $display("FAIL pad_bytes got %h %h exp a0 a1", rx_q[0], rx_q[1]);
      end
      if (eof_cnt != 1 || last_bad !== 1'b0) begin
         n_fail++; $display("FAIL pad_eof got cnt %0d bad %b exp cnt 1 bad 0", eof_cnt, last_bad);
      end
      if (last_chan !== 3'd2) begin n_fail++; $display("FAIL pad_chan got %0d exp 2", last_chan); end
   endtask

   task automatic test_drop();
      clear_mon();
      build(MY_MAC, 32'hC0A8_0199, 16'd5001, 16'd12, 4, 0);
      send(0, frm.size(), 2'b01);
      exp_drop++;
      n_checks += 3;
      if (rx_q.size() != 0) begin n_fail++; $display("FAIL dropip_dvld got %0d exp 0", rx_q.size()); end
      if (eof_cnt != 0) begin n_fail++; $display("FAIL dropip_eof got %0d exp 0", eof_cnt); end
      if (stat_drop !== 16'(exp_drop)) begin n_fail++; $display("FAIL dropip_stat got %0d exp %0d", stat_drop, exp_drop); end
      // Broadcast destination
      clear_mon();
      build(48'hFFFF_FFFF_FFFF, MY_IP, 16'd5001, 16'd12, 4, 0);
      send(0, frm.size(), 2'b01);
`ifdef GBE_RX_MUX_BCAST_EN
      n_checks++;
      if (rx_q.size() != 4) begin n_fail++; $display("FAIL bcast_count got %0d exp 4", rx_q.size()); end
`else
      exp_drop++;
      n_checks++;
      if (rx_q.size() != 0) begin n_fail++; $display("FAIL bcast_count got %0d exp 0", rx_q.size()); end
`endif
      n_checks++;
      if (stat_drop !== 16'(exp_drop)) begin n_fail++; $display("FAIL bcast_stat got %0d exp %0d", stat_drop, exp_drop); end
      // Runt ending inside the header is not counted
      clear_mon();
      build(MY_MAC, MY_IP, 16'd5001, 16'd12, 4, 0);
      send(0, 20, 2'b01);
      n_checks += 2;
      if (eof_cnt != 0) begin n_fail++; $display("FAIL runt_eof got %0d exp 0", eof_cnt); end
      if (stat_drop !== 16'(exp_drop)) begin n_fail++; $display("FAIL runt_stat got %0d exp %0d", stat_drop, exp_drop); end
      // Receiver disabled
      clear_mon();
      local_enable = 1'b0;
      send(0, frm.size(), 2'b01);
      local_enable = 1'b1;
      exp_drop++;
      n_checks += 2;
      if (rx_q.size() != 0) begin n_fail++; $display("FAIL disabled_dvld got %0d exp 0", rx_q.size()); end
      if (stat_drop !== 16'(exp_drop)) begin n_fail++; $display("FAIL disabled_stat got %0d exp %0d", stat_drop, exp_drop); end
   endtask

   task automatic test_bad_end();
      clear_mon();
      build(MY_MAC, MY_IP, 16'd5000, 16'd12, 4, 0);
      send(0, frm.size(), 2'b10);
      n_checks += 2;
      if (rx_q.size() != 4) begin n_fail++; $display("FAIL badend_count got %0d exp 4", rx_q.size()); end
      if (eof_cnt != 1 || last_bad !== 1'b1) begin
         n_fail++; $display("FAIL badend_eof got cnt %0d bad %b exp cnt 1 bad 1", eof_cnt, last_bad);
      end
      clear_mon();
      send(0, frm.size(), 2'b11);
      n_checks++;
      if (eof_cnt != 1 || last_bad !== 1'b1) begin
         n_fail++; $display("FAIL bothend_eof got cnt %0d bad %b exp cnt 1 bad 1", eof_cnt, last_bad);
      end
      clear_mon();
      send(0, 44, 2'b01);
      n_checks += 2;
      if (rx_q.size() != 2) begin n_fail++; $display("FAIL short_count got %0d exp 2", rx_q.size()); end
      if (eof_cnt != 1 || last_bad !== 1'b1) begin
         n_fail++; $display("FAIL short_eof got cnt %0d bad %b exp cnt 1 bad 1", eof_cnt, last_bad);
      end
   endtask

   task automatic test_priority();
      local_ports = {16'd7000, 16'd5000, 16'd5001, 16'd5000};
      build(MY_MAC, MY_IP, 16'd5000, 16'd12, 4, 0);
      clear_mon();
      port_en = 4'b0101;
      send(0, frm.size(), 2'b01);
      n_checks++;
      if (eof_cnt != 1 || last_chan !== 3'd0) begin
         n_fail++; $display("FAIL prio_low got cnt %0d chan %0d exp cnt 1 chan 0", eof_cnt, last_chan);
      end
      clear_mon();
      port_en = 4'b0100;
      send(0, frm.size(), 2'b01);
      n_checks++;
      if (eof_cnt != 1 || last_chan !== 3'd2) begin
         n_fail++; $display("FAIL prio_en got cnt %0d chan %0d exp cnt 1 chan 2", eof_cnt, last_chan);
      end
      clear_mon();
      port_en = 4'b1010;
      send(0, frm.size(), 2'b01);
      exp_drop++;
      n_checks += 2;
      if (eof_cnt != 0) begin n_fail++; $display("FAIL prio_none_eof got %0d exp 0", eof_cnt); end
      if (stat_drop !== 16'(exp_drop)) begin n_fail++; $display("FAIL prio_none_stat got %0d exp %0d", stat_drop, exp_drop); end
      port_en = 4'b1111;
      local_ports = PORTS_DEF;
   endtask

   task automatic test_reset_mid();
      clear_mon();
      build(MY_MAC, MY_IP, 16'd5001, 16'd12, 4, 0);
      send(0, 45, 2'b00);
      n_checks++;
      if (rx_q.size() != 3) begin n_fail++; $display("FAIL midrst_pre got %0d exp 3", rx_q.size()); end
      @(negedge app_clk);
      app_rst = 1'b1;
      #1;
      n_checks += 4;
      if (app_dvld !== 1'b0 || app_eof !== 1'b0) begin
         n_fail++; $display("FAIL midrst_flags got dvld %b eof %b exp 0 0", app_dvld, app_eof);
      end
      if (app_chan !== 3'd0 || app_data !== 8'd0) begin
         n_fail++; $display("FAIL midrst_chan_data got %0d %h exp 0 00", app_chan, app_data);
      end
      if (app_srcip !== 32'd0 || app_srcport !== 16'd0) begin
         n_fail++; $display("FAIL midrst_src got %h %h exp 0 0", app_srcip, app_srcport);
      end
      if (stat_drop !== 16'd0) begin n_fail++; $display("FAIL midrst_stat got %0d exp 0", stat_drop); end
      @(negedge app_clk);
      app_rst = 1'b0;
      exp_drop = 0;
      clear_mon();
      send(45, frm.size(), 2'b01);
      n_checks += 2;
      if (rx_q.size() != 0) begin n_fail++; $display("FAIL midrst_tail got %0d exp 0", rx_q.size()); end
      if (eof_cnt != 0) begin n_fail++; $display("FAIL midrst_eof got %0d exp 0", eof_cnt); end
      clear_mon();
      send(0, frm.size(), 2'b01);
      n_checks += 3;
      if (rx_q.size() != 4) begin n_fail++; $display("FAIL midrst_next got %0d exp 4", rx_q.size()); end
      if (rx_q.size() == 4 && rx_q[3] !== 8'hA3) begin
         n_fail++; $display("FAIL midrst_next_byte got %h exp a3", rx_q[3]);
      end
      if (eof_cnt != 1 || last_bad !== 1'b0 || last_chan !== 3'd1) begin
         n_fail++;
         $display("FAIL midrst_next_eof got cnt %0d bad %b chan %0d exp 1 0 1", eof_cnt, last_bad, last_chan);
      end
   endtask

   initial begin
      mac_rx_data      = 8'd0;
      mac_rx_dvld      = 1'b0;
      mac_rx_goodframe = 1'b0;
      mac_rx_badframe  = 1'b0;
      local_enable     = 1'b1;
      local_mac        = MY_MAC;
      local_ip         = MY_IP;
      local_ports      = PORTS_DEF;
      local_port_base  = 16'd6000;
      port_en          = 4'b1111;
      clear_mon();
      test_reset();
      test_basic();
      test_pad();
      test_drop();
      test_bad_end();
      test_priority();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
